vend_controller: RTL and testbench

Sequencing controller for the vending machine. It accumulates coin credit, validates a product selection against per-slot prices, and drives the product LED for a fixed dispense interval. It then returns leftover credit as nickel change pulses. It sits between the debounced board inputs (coin strobes, SW selection, vend/cancel buttons) and the product LEDs, replacing the single-press, price-free dispense path.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/key_pulse.sv | 25 ++
 rtl/vend_controller.sv | 134 +++++++++++++
 tb/tb_vend_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM states, coin codes and nickel values.
// Credit is always counted in nickels, so it fits in CREDIT_W bits.
package vend_pkg;

    localparam int CREDIT_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_SLUG    = 2'd3;

    localparam logic [2:0] VAL_NICKEL  = 3'd1;
    localparam logic [2:0] VAL_DIME    = 3'd2;
    localparam logic [2:0] VAL_QUARTER = 3'd5;

    function automatic logic [2:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_NICKEL:  coin_value = VAL_NICKEL;
            COIN_DIME:    coin_value = VAL_DIME;
            COIN_QUARTER: coin_value = VAL_QUARTER;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Turns an active-low push-button into a single-cycle strobe on its press edge.
// Latency 3 clocks from the key falling; no backpressure, one strobe per press.
module key_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    logic [1:0] sync;
    logic       key_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            key_prev <= 1'b1;
            pulse    <= 1'b0;
        end else begin
            sync     <= {sync[0], key};
            key_prev <= sync[1];
            pulse    <= key_prev & ~sync[1];
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coin credit, priced product selection, timed LED dispense and nickel change return.
// All outputs registered, 1-cycle response to strobes; inputs are never stalled (busy is advisory).
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0          = 5,
    parameter int PRICE1          = 5,
    parameter int PRICE2          = 7,
    parameter int PRICE3          = 10,
    parameter int MAX_CREDIT      = 40,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic [3:0]          SW,
    input  logic                vend_req,
    input  logic                cancel,
    output logic [3:0]          LED,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                short_err,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TIMER_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DISPENSE_CYCLES - 1);
    localparam logic [CREDIT_W:0]  CREDIT_MAX = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE_NICKEL = CREDIT_W'(1);

    vend_state_e          state;
    logic [TIMER_W-1:0]   timer;
    logic                 ready;
    logic                 sw_onehot;
    logic [CREDIT_W-1:0]  price;
    logic [CREDIT_W:0]    coin_sum;
    logic                 coin_fits;
    logic                 take_cancel;
    logic                 take_vend;
    logic                 vend_ok;
    logic                 take_coin;

    assign ready     = (state == IDLE) || (state == CREDIT);
    assign sw_onehot = (SW != 4'd0) && ((SW & (SW - 4'd1)) == 4'd0);

    always_comb begin
        price = CREDIT_W'(PRICE0);
        case (SW)
            4'b0010: price = CREDIT_W'(PRICE1);
            4'b0100: price = CREDIT_W'(PRICE2);
            4'b1000: price = CREDIT_W'(PRICE3);
            default: price = CREDIT_W'(PRICE0);
        endcase
    end

    assign coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_type));
    assign coin_fits = (coin_type != COIN_SLUG) && (coin_sum <= CREDIT_MAX);

    // Priority cancel > vend > coin; a coin losing to an accepted cancel/vend is bounced.
    assign take_cancel = cancel && (state == CREDIT);
    assign take_vend   = vend_req && ready && !take_cancel;
    assign vend_ok     = take_vend && sw_onehot && (credit >= price);
    assign take_coin   = coin_valid && ready && !take_cancel && !vend_ok;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            timer        <= '0;
            LED          <= 4'd0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            short_err    <= 1'b0;
            credit       <= '0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= coin_valid && !(take_coin && coin_fits);
            sel_err     <= take_vend && !sw_onehot;
            short_err   <= take_vend && sw_onehot && (credit < price);

            case (state)
                IDLE, CREDIT: begin
                    if (take_cancel) begin
                        state        <= CHANGE;
                        busy         <= 1'b1;
                        change_pulse <= 1'b1;
                        credit       <= credit - ONE_NICKEL;
                    end else if (vend_ok) begin
                        state  <= DISPENSE;
                        busy   <= 1'b1;
                        LED    <= SW;
                        credit <= credit - price;
                        timer  <= '0;
                    end else if (take_coin && coin_fits) begin
                        state  <= CREDIT;
                        credit <= coin_sum[CREDIT_W-1:0];
                    end
                end
                DISPENSE: begin
                    if (timer == TIMER_LAST) begin
                        LED <= 4'd0;
                        if (credit != '0) begin
                            state        <= CHANGE;
                            change_pulse <= 1'b1;
                            credit       <= credit - ONE_NICKEL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                CHANGE: begin
                    // Credit is taken as each pulse goes high; the low cycle after the last pulse ends the run.
                    if (change_pulse) begin
                        change_pulse <= 1'b0;
                    end else if (credit != '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - ONE_NICKEL;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed plus randomized bench for vend_controller (and the key_pulse strobe helper),
// compared every cycle against a transaction-level model of the vending rules.
module tb_vend_controller;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type  = 2'd0;
    logic [3:0] SW         = 4'd0;
    logic       vend_req   = 1'b0;
    logic       cancel     = 1'b0;
    logic [3:0] LED;
    logic       change_pulse;
    logic       coin_reject;
    logic       sel_err;
    logic       short_err;
    logic [5:0] credit;
    logic       busy;
    logic       key_in = 1'b1;
    logic       key_strobe;

    localparam int DC = 4;
    localparam int MAXC = 40;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int led_cnt   = 0;

    // Model: mode 0 = ready for coins/vend, 1 = dispensing, 2 = returning change.
    int       m_mode;
    int       m_credit;
    logic [3:0] m_led;
    int       d_left;
    int       chg_n;
    int       chg_k;
    bit       e_rej, e_sel, e_short;

    always #10 CLOCK_50 = ~CLOCK_50;

    vend_controller dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .SW           (SW),
        .vend_req     (vend_req),
        .cancel       (cancel),
        .LED          (LED),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
        .short_err    (short_err),
        .credit       (credit),
        .busy         (busy)
    );

    key_pulse kp (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key   (key_in),
        .pulse (key_strobe)
    );

    function automatic int price_of(input logic [3:0] sw);
        int prices [4];
        prices = '{5, 5, 7, 10};
        price_of = 0;
        for (int b = 0; b < 4; b++)
            if (sw[b]) price_of = prices[b];
    endfunction

    function automatic int nickels(input logic [1:0] ct);
        case (ct)
            2'd0:    nickels = 1;
            2'd1:    nickels = 2;
            2'd2:    nickels = 5;
            default: nickels = 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_led = 4'd0; d_left = 0;
        chg_n = 0; chg_k = 0; e_rej = 0; e_sel = 0; e_short = 0;
    endtask

    task automatic start_change();
        chg_n = m_credit; chg_k = 0; m_credit = 0; m_mode = 2;
    endtask

    task automatic model_step(input bit cv, input logic [1:0] ct, input logic [3:0] sw,
                              input bit vr, input bit cn);
        bit took;
        took = 0;
        e_rej = 0; e_sel = 0; e_short = 0;
        if (m_mode == 0) begin
            if (cn && m_credit > 0) begin
                took = 1;
                start_change();
            end else if (vr) begin
                if ($countones(sw) != 1) e_sel = 1;
                else if (m_credit < price_of(sw)) e_short = 1;
                else begin
                    took = 1;
                    m_credit -= price_of(sw);
                    m_led = sw;
                    m_mode = 1;
                    d_left = DC;
                end
            end
            if (cv) begin
                if (!took && ct != 2'd3 && m_credit + nickels(ct) <= MAXC) m_credit += nickels(ct);
                else e_rej = 1;
            end
        end else if (m_mode == 1) begin
            e_rej = cv;
            d_left--;
            if (d_left == 0) begin
                m_led = 4'd0;
                if (m_credit > 0) start_change();
                else m_mode = 0;
            end
        end else begin
            e_rej = cv;
            chg_k++;
            if (chg_k == 2 * chg_n) m_mode = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int exp_credit;
        exp_credit = (m_mode == 2) ? (chg_n - 1 - chg_k / 2) : m_credit;
        chk("led", LED, m_led);
        chk("credit", credit, exp_credit);
        chk("change_pulse", change_pulse, (m_mode == 2 && chg_k % 2 == 0) ? 1 : 0);
        chk("busy", busy, (m_mode != 0) ? 1 : 0);
        chk("coin_reject", coin_reject, e_rej);
        chk("sel_err", sel_err, e_sel);
        chk("short_err", short_err, e_short);
        if (change_pulse === 1'b1) pulse_cnt++;
        if (LED !== 4'd0) led_cnt++;
    endtask

    task automatic step(input bit cv, input logic [1:0] ct, input logic [3:0] sw,
                        input bit vr, input bit cn);
        coin_valid = cv; coin_type = ct; SW = sw; vend_req = vr; cancel = cn;
        @(posedge CLOCK_50);
        model_step(cv, ct, sw, vr, cn);
        #1;
        coin_valid = 1'b0; vend_req = 1'b0; cancel = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 2'd0, SW, 1'b0, 1'b0);
    endtask

    initial begin
        bit         r_cv, r_vr, r_cn;
        logic [1:0] r_ct;
        logic [3:0] r_sw;
        int         strobes;

        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_outputs();
        chk("reset_key_strobe", key_strobe, 0);
        RESET_N = 1'b1;

        // Two quarters, buy slot 2 (7), expect 4 LED cycles then 3 nickels back.
        step(1'b1, 2'd2, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 2'd2, 4'b0100, 1'b0, 1'b0);
        chk("t1_credit_10", credit, 10);
        pulse_cnt = 0; led_cnt = 0;
        step(1'b0, 2'd0, 4'b0100, 1'b1, 1'b0);
        idle(12);
        chk("t1_led_cycles", led_cnt, 4);
        chk("t1_change_pulses", pulse_cnt, 3);

        // Short credit, then bad selection.
        step(1'b1, 2'd2, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 2'd0, 4'b1000, 1'b1, 1'b0);
        chk("t2_short_err", short_err, 1);
        step(1'b0, 2'd0, 4'b0011, 1'b1, 1'b0);
        chk("t3_sel_err", sel_err, 1);
        chk("t3_credit_kept", credit, 5);

        // Ceiling: 5 -> 38, quarter bounced, dime fills to 40, slug bounced.
        for (int q = 0; q < 6; q++) step(1'b1, 2'd2, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 2'd1, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'b0011, 1'b0, 1'b0);
        chk("t4_credit_38", credit, 38);
        step(1'b1, 2'd2, 4'b0011, 1'b0, 1'b0);
        chk("t4_quarter_reject", coin_reject, 1);
        step(1'b1, 2'd1, 4'b0011, 1'b0, 1'b0);
        chk("t4_credit_40", credit, 40);
        step(1'b1, 2'd3, 4'b0011, 1'b0, 1'b0);
        chk("t4_slug_reject", coin_reject, 1);
        pulse_cnt = 0;
        step(1'b0, 2'd0, 4'b0011, 1'b0, 1'b1);
        idle(84);
        chk("t4_refund_pulses", pulse_cnt, 40);

        // Credit 7, cancel with a quarter in the same cycle.
        step(1'b1, 2'd2, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 2'd1, 4'b0001, 1'b0, 1'b0);
        pulse_cnt = 0;
        step(1'b1, 2'd2, 4'b0001, 1'b0, 1'b1);
        chk("t5_coin_reject", coin_reject, 1);
        idle(16);
        chk("t5_change_pulses", pulse_cnt, 7);

        // Cancel beats a simultaneous valid vend.
        step(1'b1, 2'd2, 4'b0001, 1'b0, 1'b0);
        pulse_cnt = 0; led_cnt = 0;
        step(1'b0, 2'd0, 4'b0001, 1'b1, 1'b1);
        idle(12);
        chk("t5b_no_led", led_cnt, 0);
        chk("t5b_refund", pulse_cnt, 5);

        // Reset in the 2nd dispense cycle with 5 nickels still owed.
        step(1'b1, 2'd2, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 2'd2, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        step(1'b0, 2'd0, 4'b0001, 1'b0, 1'b0);
        RESET_N = 1'b0;
        #1;
        model_reset();
        chk("t6_led_cleared", LED, 0);
        chk("t6_credit_cleared", credit, 0);
        chk("t6_busy_cleared", busy, 0);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        pulse_cnt = 0;
        idle(12);
        chk("t6_no_change", pulse_cnt, 0);

        // Key press yields exactly one strobe; release yields none.
        strobes = 0;
        key_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (key_strobe === 1'b1) strobes++;
        end
        chk("key_press_strobes", strobes, 1);
        strobes = 0;
        key_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (key_strobe === 1'b1) strobes++;
        end
        chk("key_release_strobes", strobes, 0);
        idle(1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            r_cv = ($urandom_range(0, 2) == 0);
            r_ct = 2'($urandom_range(0, 3));
            r_sw = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'(1 << $urandom_range(0, 3));
            r_vr = ($urandom_range(0, 6) == 0);
            r_cn = ($urandom_range(0, 24) == 0);
            step(r_cv, r_ct, r_sw, r_vr, r_cn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
